// File: rtl/mult_booth_ctrl.sv
// mult_booth_ctrl: radix-2 Booth sequencer for a signed 32x32 multiply on a shared external adder
// Ports: i_clock/i_reset (async active-low), i_start with i_operand_a (M) / i_operand_b (Q),
// o_adder_a/o_adder_b/o_adder_cin driven to the RCA, i_adder_sum/i_adder_cout from it,
// o_busy (RUN), o_result_rdy (one-cycle DONE pulse), o_result (low product word), o_exception (overflow).
module mult_booth_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  output logic [WIDTH-1:0] o_adder_a,
  output logic [WIDTH-1:0] o_adder_b,
  output logic             o_adder_cin,
  input  logic [WIDTH-1:0] i_adder_sum,
  input  logic             i_adder_cout,
  output logic             o_busy,
  output logic             o_result_rdy,
  output logic [WIDTH-1:0] o_result,
  output logic             o_exception
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_m, r_p_hi, r_p_lo;
  logic             r_q_m1;
  logic             w_run, w_add, w_sub, w_v, w_s, w_unused;
  logic [WIDTH-1:0] w_hi_nx, w_lo_nx;
  assign w_unused = i_adder_cout;
  assign w_run = r_state == RUN;
  assign w_add = w_run && !r_p_lo[0] && r_q_m1;
  assign w_sub = w_run && r_p_lo[0] && !r_q_m1;
  assign o_adder_a = w_run ? r_p_hi : '0;
  assign o_adder_b = w_add ? r_m : w_sub ? ~r_m : '0;
  assign o_adder_cin = w_sub;
  // The 32-bit sum can wrap (e.g. 0 - 0x80000000); v recovers the true sign bit for the shift-in.
  assign w_v = (o_adder_a[WIDTH-1] == o_adder_b[WIDTH-1]) && (i_adder_sum[WIDTH-1] != o_adder_a[WIDTH-1]);
  assign w_s = i_adder_sum[WIDTH-1] ^ w_v;
  assign w_hi_nx = {w_s, i_adder_sum[WIDTH-1:1]};
  assign w_lo_nx = {i_adder_sum[0], r_p_lo[WIDTH-1:1]};
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_m <= '0;
      r_p_hi <= '0;
      r_p_lo <= '0;
      r_q_m1 <= 1'b0;
      o_busy <= 1'b0;
      o_result_rdy <= 1'b0;
      o_result <= '0;
      o_exception <= 1'b0;
    end else begin
      o_result_rdy <= 1'b0;
      if (w_run) begin
        r_p_hi <= w_hi_nx;
        r_p_lo <= w_lo_nx;
        r_q_m1 <= r_p_lo[0];
        r_cnt <= r_cnt + 5'd1;
        if (r_cnt == 5'd31) begin
          r_state <= DONE;
          o_busy <= 1'b0;
          o_result_rdy <= 1'b1;
          o_result <= w_lo_nx;
          o_exception <= w_hi_nx != {WIDTH{w_lo_nx[WIDTH-1]}};
        end
      end else if (i_start) begin
        r_state <= RUN;
        r_cnt <= '0;
        r_m <= i_operand_a;
        r_p_hi <= '0;
        r_p_lo <= i_operand_b;
        r_q_m1 <= 1'b0;
        o_busy <= 1'b1;
      end else begin
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mult_booth_ctrl.sv
// tb_mult_booth_ctrl: directed self-checking bench for mult_booth_ctrl with a behavioural adder
module tb_mult_booth_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] opa = '0, opb = '0;
  logic [31:0] adder_a, adder_b, adder_sum, result;
  logic        adder_cin, adder_cout, busy, rdy, exc;
  int          tests = 0, fails = 0, cyc = 0;

  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {32'd0, adder_cin};

  mult_booth_ctrl dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start),
    .i_operand_a(opa), .i_operand_b(opb),
    .o_adder_a(adder_a), .o_adder_b(adder_b), .o_adder_cin(adder_cin),
    .i_adder_sum(adder_sum), .i_adder_cout(adder_cout),
    .o_busy(busy), .o_result_rdy(rdy), .o_result(result), .o_exception(exc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int inj,
                       output int lat, output int bz, output logic [31:0] res,
                       output logic ex, output int acc);
    @(negedge clk);
    start = 1'b1; opa = a; opb = b;
    @(posedge clk);
    #1 start = 1'b0;
    acc = cyc;
    bz = busy ? 1 : 0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 lat++;
      if (rdy) break;
      bz += busy ? 1 : 0;
      if (inj != 0 && lat == inj) begin
        start = 1'b1; opa = 32'd9; opb = 32'd9;
      end else start = 1'b0;
    end
    start = 1'b0;
    if (!rdy) lat = -1;
    res = result;
    ex = exc;
  endtask

  task automatic test_reset;
    #3;
    tests++;
    if ({busy, rdy, exc, result, adder_a, adder_b, adder_cin} !== '0) begin
      fails++;
      $display("FAIL reset: busy=%b rdy=%b exc=%b result=%h adder_a=%h adder_b=%h cin=%b, want all 0",
               busy, rdy, exc, result, adder_a, adder_b, adder_cin);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat, bz, acc; logic [31:0] r; logic e;
    do_op(32'd3, 32'd5, 0, lat, bz, r, e, acc);
    tests++; if (lat !== 32) begin fails++; $display("FAIL basic_latency: got %0d want 32", lat); end
    tests++; if (bz !== 32) begin fails++; $display("FAIL basic_busy_cycles: got %0d want 32", bz); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_in_done: got %b want 0", busy); end
    tests++; if (r !== 32'd15 || e !== 1'b0) begin fails++; $display("FAIL basic_3x5: got %h/%b want 0000000f/0", r, e); end
    @(posedge clk); #1;
    tests++; if (rdy !== 1'b0 || result !== 32'd15) begin fails++; $display("FAIL basic_hold: rdy=%b result=%h want 0/0000000f", rdy, result); end
  endtask

  task automatic test_signed;
    int lat, bz, acc; logic [31:0] r; logic e;
    do_op(-32'sd7, 32'd6, 0, lat, bz, r, e, acc);
    tests++; if (r !== 32'hFFFFFFD6 || e !== 1'b0 || lat !== 32) begin fails++; $display("FAIL neg7x6: got %h/%b lat %0d want ffffffd6/0 lat 32", r, e, lat); end
  endtask

  task automatic test_overflow;
    int lat, bz, acc; logic [31:0] r; logic e;
    do_op(32'h7FFFFFFF, 32'd2, 0, lat, bz, r, e, acc);
    tests++; if (r !== 32'hFFFFFFFE || e !== 1'b1) begin fails++; $display("FAIL max_x2: got %h/%b want fffffffe/1", r, e); end
    do_op(32'h80000000, 32'hFFFFFFFF, 0, lat, bz, r, e, acc);
    tests++; if (r !== 32'h80000000 || e !== 1'b1) begin fails++; $display("FAIL min_xneg1: got %h/%b want 80000000/1", r, e); end
    do_op(32'h80000000, 32'd1, 0, lat, bz, r, e, acc);
    tests++; if (r !== 32'h80000000 || e !== 1'b0) begin fails++; $display("FAIL min_x1: got %h/%b want 80000000/0", r, e); end
  endtask

  task automatic test_start_in_run;
    int lat, bz, acc; logic [31:0] r; logic e;
    do_op(32'd100, 32'd7, 10, lat, bz, r, e, acc);
    tests++; if (r !== 32'd700 || e !== 1'b0 || lat !== 32) begin fails++; $display("FAIL start_in_run: got %h/%b lat %0d want 000002bc/0 lat 32", r, e, lat); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_in_run_no_queue: busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int lat, bz, acc1, acc2; logic [31:0] r; logic e;
    do_op(32'd5, 32'd5, 0, lat, bz, r, e, acc1);
    tests++; if (r !== 32'd25) begin fails++; $display("FAIL b2b_first: got %h want 00000019", r); end
    do_op(32'd4, 32'd4, 0, lat, bz, r, e, acc2);
    tests++; if (acc2 - acc1 !== 33) begin fails++; $display("FAIL b2b_interval: got %0d want 33", acc2 - acc1); end
    tests++; if (r !== 32'd16 || e !== 1'b0 || lat !== 32) begin fails++; $display("FAIL b2b_4x4: got %h/%b lat %0d want 00000010/0 lat 32", r, e, lat); end
  endtask

  task automatic test_reset_mid;
    int lat, bz, acc, seen; logic [31:0] r; logic e;
    @(negedge clk);
    start = 1'b1; opa = 32'h1234; opb = 32'h55;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, rdy, exc, result, adder_a, adder_b, adder_cin} !== '0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b rdy=%b exc=%b result=%h adder_a=%h adder_b=%h, want all 0",
               busy, rdy, exc, result, adder_a, adder_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (rdy || busy) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL reset_mid_no_rdy: activity in %0d cycles, want 0", seen); end
    do_op(32'd0, 32'h12345678, 0, lat, bz, r, e, acc);
    tests++; if (r !== 32'd0 || e !== 1'b0 || lat !== 32) begin fails++; $display("FAIL after_reset_0x: got %h/%b lat %0d want 00000000/0 lat 32", r, e, lat); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signed;
    test_overflow;
    test_start_in_run;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
